// File: rtl/vga_seq_pkg.sv
// Shared opcodes, FSM state encoding and reset defaults for the VGA frame sequencer.
package vga_seq_pkg;

  localparam logic [2:0] OP_NOP        = 3'd0;
  localparam logic [2:0] OP_RUN        = 3'd1;
  localparam logic [2:0] OP_STOP       = 3'd2;
  localparam logic [2:0] OP_STEP       = 3'd3;
  localparam logic [2:0] OP_SET_SPEED  = 3'd4;
  localparam logic [2:0] OP_SET_MODE   = 3'd5;
  localparam logic [2:0] OP_SET_DIR    = 3'd6;
  localparam logic [2:0] OP_LOAD_PHASE = 3'd7;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_STOP = 1'b1
  } seq_state_t;

  localparam seq_state_t RST_STATE = ST_RUN;
  localparam logic       RST_DIR   = 1'b0;

endpackage

// File: rtl/vga_frame_edge.sv
// Normalises vsync polarity and produces a one-clock frame-start pulse on
// the inactive-to-active transition, entirely in the pixel clock domain.
module vga_frame_edge
  import vga_seq_pkg::*;
#(
  parameter bit VSYNC_POL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync,
  output logic fs
);

  logic vsync_act_s;
  logic vsync_q_r;

  assign vsync_act_s = VSYNC_POL ? vsync : ~vsync;

  // previous-cycle copy of the active-high vsync
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q_r <= 1'b0;
    end else begin
      vsync_q_r <= vsync_act_s;
    end
  end

  assign fs = vsync_act_s & ~vsync_q_r;

endmodule

// File: rtl/vga_frame_sequencer.sv
// Frame-synchronous animation controller: one-entry command slot, RUN/STOP
// FSM, prescaler and phase/mode registers, all committed at frame start.
module vga_frame_sequencer
  import vga_seq_pkg::*;
#(
  parameter int PHASE_W   = 10,
  parameter int SPEED_W   = 3,
  parameter int MODE_W    = 2,
  parameter int VSYNC_POL = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vsync,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [PHASE_W-1:0] cmd_arg,
  output logic [PHASE_W-1:0] phase,
  output logic [MODE_W-1:0]  mode,
  output logic               running,
  output logic               frame_tick
);

  localparam logic [PHASE_W-1:0] PHASE_ONE  = {{(PHASE_W-1){1'b0}}, 1'b1};
  localparam logic [SPEED_W-1:0] PRESC_ONE  = {{(SPEED_W-1){1'b0}}, 1'b1};
  localparam logic [SPEED_W-1:0] PRESC_ZERO = {SPEED_W{1'b0}};

  seq_state_t         state_r, state_nxt_s;
  logic               pend_vld_r;
  logic [2:0]         pend_op_r;
  logic [PHASE_W-1:0] pend_arg_r;
  logic [SPEED_W-1:0] speed_r, speed_nxt_s;
  logic [SPEED_W-1:0] presc_r, presc_nxt_s;
  logic               dir_r, dir_nxt_s;
  logic [PHASE_W-1:0] phase_r, phase_nxt_s;
  logic [MODE_W-1:0]  mode_r, mode_nxt_s;
  logic               tick_r, tick_nxt_s;
  logic               fs_s, accept_s, commit_s, advance_s;
  logic [2:0]         op_s;

  vga_frame_edge #(
    .VSYNC_POL (VSYNC_POL != 0)
  ) u_frame_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .vsync (vsync),
    .fs    (fs_s)
  );

  // Accept and commit are mutually exclusive, so a command taken in the
  // frame-start cycle naturally waits for the following frame start.
  assign cmd_ready = ~pend_vld_r;
  assign accept_s  = cmd_valid & ~pend_vld_r;
  assign commit_s  = fs_s & pend_vld_r;
  assign op_s      = commit_s ? pend_op_r : OP_NOP;

  // one-entry pending command slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld_r <= 1'b0;
      pend_op_r  <= OP_NOP;
      pend_arg_r <= {PHASE_W{1'b0}};
    end else if (accept_s) begin
      pend_vld_r <= 1'b1;
      pend_op_r  <= cmd_op;
      pend_arg_r <= cmd_arg;
    end else if (commit_s) begin
      pend_vld_r <= 1'b0;
    end
  end

  // RUN/STOP state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RST_STATE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // frame-boundary decision: advance uses pre-commit state, speed and dir
  always_comb begin
    state_nxt_s = state_r;
    speed_nxt_s = speed_r;
    dir_nxt_s   = dir_r;
    presc_nxt_s = presc_r;
    phase_nxt_s = phase_r;
    mode_nxt_s  = mode_r;
    advance_s   = 1'b0;
    tick_nxt_s  = 1'b0;
    if (fs_s) begin
      if (state_r == ST_RUN) begin
        advance_s   = (presc_r == speed_r);
        presc_nxt_s = advance_s ? PRESC_ZERO : (presc_r + PRESC_ONE);
      end else begin
        advance_s = (op_s == OP_STEP);
      end
      if (advance_s) begin
        phase_nxt_s = dir_r ? (phase_r - PHASE_ONE) : (phase_r + PHASE_ONE);
      end else begin
        phase_nxt_s = phase_r;
      end
      case (op_s)
        OP_RUN: begin
          state_nxt_s = ST_RUN;
          presc_nxt_s = PRESC_ZERO;
        end
        OP_STOP:       state_nxt_s = ST_STOP;
        OP_SET_SPEED:  speed_nxt_s = pend_arg_r[SPEED_W-1:0];
        OP_SET_MODE:   mode_nxt_s  = pend_arg_r[MODE_W-1:0];
        OP_SET_DIR:    dir_nxt_s   = pend_arg_r[0];
        OP_LOAD_PHASE: begin
          phase_nxt_s = pend_arg_r;
          presc_nxt_s = PRESC_ZERO;
        end
        default: begin
          state_nxt_s = state_r;
        end
      endcase
      tick_nxt_s = (phase_nxt_s != phase_r) | (mode_nxt_s != mode_r);
    end else begin
      tick_nxt_s = 1'b0;
    end
  end

  // datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      speed_r <= PRESC_ZERO;
      presc_r <= PRESC_ZERO;
      dir_r   <= RST_DIR;
      phase_r <= {PHASE_W{1'b0}};
      mode_r  <= {MODE_W{1'b0}};
      tick_r  <= 1'b0;
    end else begin
      speed_r <= speed_nxt_s;
      presc_r <= presc_nxt_s;
      dir_r   <= dir_nxt_s;
      phase_r <= phase_nxt_s;
      mode_r  <= mode_nxt_s;
      tick_r  <= tick_nxt_s;
    end
  end

  assign phase      = phase_r;
  assign mode       = mode_r;
  assign frame_tick = tick_r;
  assign running    = (state_r == ST_RUN);

endmodule

// File: tb/tb_vga_frame_sequencer.sv
// Randomised and directed bench for vga_frame_sequencer against a
// frame-level behavioural model (integers and a pending-command queue).
module tb_vga_frame_sequencer;

  localparam int PHASE_W = 10;
  localparam int SPEED_W = 3;
  localparam int MODE_W  = 2;
  localparam int PMOD    = 1 << PHASE_W;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               vsync = 1'b0;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [2:0]         cmd_op = 3'd0;
  logic [PHASE_W-1:0] cmd_arg = '0;
  logic [PHASE_W-1:0] phase;
  logic [MODE_W-1:0]  mode;
  logic               running;
  logic               frame_tick;

  vga_frame_sequencer #(
    .PHASE_W(PHASE_W), .SPEED_W(SPEED_W), .MODE_W(MODE_W), .VSYNC_POL(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vsync(vsync), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .phase(phase), .mode(mode), .running(running), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int m_phase, m_mode, m_speed, m_dir, m_presc, m_run, m_tick, m_vs_prev;
  int pend_op[$];
  int pend_arg[$];

  bit                 want_v = 1'b0;
  logic [2:0]         want_op = 3'd0;
  logic [PHASE_W-1:0] want_arg = '0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_mode = 0; m_speed = 0; m_dir = 0;
    m_presc = 0; m_run = 1; m_tick = 0; m_vs_prev = 0;
    pend_op.delete();
    pend_arg.delete();
  endtask

  // frame-start rules applied to the model
  task automatic model_fs();
    int adv, has, op, arg, new_phase, new_mode;
    has = (pend_op.size() != 0);
    op  = has ? pend_op[0] : 0;
    arg = has ? pend_arg[0] : 0;
    adv = 0;
    if (m_run != 0) begin
      if (m_presc == m_speed) begin
        adv = 1;
        m_presc = 0;
      end else begin
        m_presc = (m_presc + 1) % (1 << SPEED_W);
      end
    end else if (op == 3) begin
      adv = 1;
    end
    new_phase = m_phase;
    new_mode  = m_mode;
    if (adv != 0) new_phase = (m_dir != 0) ? (m_phase + PMOD - 1) % PMOD : (m_phase + 1) % PMOD;
    case (op)
      1: begin m_run = 1; m_presc = 0; end
      2: m_run = 0;
      4: m_speed = arg % (1 << SPEED_W);
      5: new_mode = arg % (1 << MODE_W);
      6: m_dir = arg % 2;
      7: begin new_phase = arg; m_presc = 0; end
      default: ;
    endcase
    m_tick  = (new_phase != m_phase || new_mode != m_mode) ? 1 : 0;
    m_phase = new_phase;
    m_mode  = new_mode;
    pend_op.delete();
    pend_arg.delete();
  endtask

  // one clock: drive, check outputs at negedge, advance model after posedge
  task automatic step(input bit vs);
    bit fs, acc;
    vsync = vs; cmd_valid = want_v; cmd_op = want_op; cmd_arg = want_arg;
    @(negedge clk);
    check("phase", int'(phase), m_phase);
    check("mode", int'(mode), m_mode);
    check("frame_tick", int'(frame_tick), m_tick);
    check("running", int'(running), m_run);
    check("cmd_ready", int'(cmd_ready), (pend_op.size() == 0) ? 1 : 0);
    fs  = vs && (m_vs_prev == 0);
    acc = want_v && (pend_op.size() == 0);
    @(posedge clk);
    #1;
    if (fs) model_fs();
    else m_tick = 0;
    if (acc) begin
      pend_op.push_back(int'(want_op));
      pend_arg.push_back(int'(want_arg));
      want_v = 1'b0;
    end
    m_vs_prev = vs ? 1 : 0;
  endtask

  task automatic frame(input int len, input int vs_w, input int at, input int op, input int arg);
    for (int c = 0; c < len; c++) begin
      if (c == at && !want_v) begin
        want_v = 1'b1; want_op = op[2:0]; want_arg = arg[PHASE_W-1:0];
      end
      step(c < vs_w);
    end
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) frame(12, 2, -1, 0, 0);
  endtask

  initial begin
    int len, vw, at, op, arg, r;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_phase", int'(phase), 0);
    check("rst_ready", int'(cmd_ready), 1);
    check("rst_running", int'(running), 1);
    check("rst_tick", int'(frame_tick), 0);
    rst_n = 1'b1;

    frames(5);
    check("t1_phase", int'(phase), 5);
    check("t1_ready", int'(cmd_ready), 1);

    frame(12, 2, 4, 4, 2);
    frames(10);
    check("t2_phase", int'(phase), 10);

    frame(12, 2, 4, 2, 0);
    frames(4);
    check("t3_stopped", int'(phase), 10);
    check("t3_running", int'(running), 0);
    frame(12, 2, 4, 3, 0);
    frames(1);
    check("t3_step", int'(phase), 11);
    frame(12, 2, 4, 1, 0);
    frames(4);
    check("t3_resume", int'(phase), 12);

    frame(12, 2, 4, 4, 0);
    frame(12, 2, 4, 7, 5);
    frame(12, 2, 4, 6, 1);
    frame(12, 2, 4, 7, 0);
    frames(1);
    check("t4_load0", int'(phase), 0);
    frames(1);
    check("t4_wrap_rev", int'(phase), PMOD - 1);
    frame(12, 2, 4, 6, 0);
    frame(12, 2, 4, 7, PMOD - 1);
    frames(1);
    check("t4_load_max", int'(phase), PMOD - 1);
    frames(1);
    check("t4_wrap_fwd", int'(phase), 0);

    frame(12, 2, 0, 5, 3);
    check("t5_fs_accept", int'(mode), 0);
    want_v = 1'b1; want_op = 3'd5; want_arg = 10'd1;
    frames(1);
    check("t5_commit", int'(mode), 3);
    frames(1);
    check("t5_held", int'(mode), 1);

    want_v = 1'b1; want_op = 3'd7; want_arg = 10'd500;
    for (int c = 0; c < 5; c++) step(c < 2);
    #3 rst_n = 1'b0;
    #1;
    check("t6_phase", int'(phase), 0);
    check("t6_mode", int'(mode), 0);
    check("t6_ready", int'(cmd_ready), 1);
    check("t6_running", int'(running), 1);
    check("t6_tick", int'(frame_tick), 0);
    model_reset();
    want_v = 1'b0; vsync = 1'b0; cmd_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    frames(3);
    check("t6_after", int'(phase), 3);

    for (int i = 0; i < 250; i++) begin
      len = int'($urandom_range(6, 20));
      vw  = int'($urandom_range(1, 3));
      at  = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, len - 1));
      op  = int'($urandom_range(0, 7));
      r   = int'($urandom_range(0, 3));
      arg = (r == 0) ? 0 : (r == 1) ? PMOD - 1 : int'($urandom_range(0, PMOD - 1));
      frame(len, vw, at, op, arg);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
